// File: rtl/life_step_sequencer.sv
// Game of Life generation controller: scans the grid one cell per clock through a single
// neighbour popcount into a shadow buffer, then commits it. Define LIFE_WRAP_EN for toroidal edges.
module life_step_sequencer #(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      LOAD,
   input  logic [WIDTH*HEIGHT-1:0]   LOAD_DATA,
   input  logic                      START,
   output logic [WIDTH*HEIGHT-1:0]   GRID,
   output logic                      BUSY,
   output logic                      DONE,
   output logic [15:0]               GENERATION
);

   localparam int CELLS = WIDTH * HEIGHT;
   localparam int IDX_W = $clog2(CELLS);
   localparam int ROW_W = $clog2(HEIGHT);
   localparam int COL_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   state_t             state;
   state_t             state_next;
   logic [ROW_W-1:0]   row;
   logic [COL_W-1:0]   col;
   logic [CELLS-1:0]   next_buf;
   logic [IDX_W-1:0]   cur_idx;
   logic [7:0]         nbr;
   logic [3:0]         count;
   logic               alive;
   logic               next_bit;
   logic               last_cell;

   assign cur_idx   = IDX_W'(int'(row) * WIDTH + int'(col));
   assign alive     = GRID[cur_idx];
   assign last_cell = (row == ROW_W'(HEIGHT - 1)) && (col == COL_W'(WIDTH - 1));

   // Neighbour mux: gather the eight cells around (row,col); off-grid handling depends on the edge mode.
   always_comb begin
      nbr = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            int   nr;
            int   nc;
            int   slot;
            logic on_grid;
            nr   = int'(row) + dr;
            nc   = int'(col) + dc;
            slot = (dr + 1) * 3 + (dc + 1);
            if (slot > 4) begin
               slot = slot - 1;
            end
`ifdef LIFE_WRAP_EN
            if (nr < 0) begin
               nr = HEIGHT - 1;
            end else if (nr >= HEIGHT) begin
               nr = 0;
            end
            if (nc < 0) begin
               nc = WIDTH - 1;
            end else if (nc >= WIDTH) begin
               nc = 0;
            end
            on_grid = 1'b1;
`else
            on_grid = (nr >= 0) && (nr < HEIGHT) && (nc >= 0) && (nc < WIDTH);
`endif
            if (!(dr == 0 && dc == 0) && on_grid) begin
               nbr[3'(slot)] = GRID[IDX_W'(nr * WIDTH + nc)];
            end
         end
      end
   end

   assign count    = 4'($countones(nbr));
   assign next_bit = (count == 4'd3) | (alive & (count == 4'd2));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // LOAD wins over START in IDLE; both are ignored once a step is underway.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!LOAD && START) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (last_cell) begin
               state_next = COMMIT;
            end
         end
         COMMIT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         row        <= '0;
         col        <= '0;
         next_buf   <= '0;
         GRID       <= '0;
         GENERATION <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (LOAD) begin
                  GRID       <= LOAD_DATA;
                  GENERATION <= '0;
               end else if (START) begin
                  row  <= '0;
                  col  <= '0;
                  BUSY <= 1'b1;
               end
            end
            SCAN: begin
               next_buf[cur_idx] <= next_bit;
               if (col == COL_W'(WIDTH - 1)) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end
            COMMIT: begin
               GRID       <= next_buf;
               GENERATION <= GENERATION + 16'd1;
               DONE       <= 1'b1;
               BUSY       <= 1'b0;
            end
            default: begin
               BUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_life_step_sequencer.sv
// Self-checking bench for life_step_sequencer: a generation-level reference model compared
// every cycle, plus hand-computed grid patterns for blinker, block, edge and handshake cases.
module tb_life_step_sequencer;

   localparam int W     = 8;
   localparam int H     = 8;
   localparam int CELLS = W * H;

   logic             CLK = 1'b0;
   logic             RST;
   logic             LOAD;
   logic [CELLS-1:0] LOAD_DATA;
   logic             START;
   logic [CELLS-1:0] GRID;
   logic             BUSY;
   logic             DONE;
   logic [15:0]      GENERATION;

   int tests = 0;
   int fails = 0;
   bit checkEnable = 1'b0;

   logic [CELLS-1:0] mGrid = '0;
   logic [15:0]      mGen = '0;
   logic             mBusy = 1'b0;
   logic             mDone = 1'b0;
   int               mCycles = 0;

   life_step_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
      .CLK(CLK),
      .RST(RST),
      .LOAD(LOAD),
      .LOAD_DATA(LOAD_DATA),
      .START(START),
      .GRID(GRID),
      .BUSY(BUSY),
      .DONE(DONE),
      .GENERATION(GENERATION)
   );

   always #5 CLK = ~CLK;

   function automatic logic [CELLS-1:0] cellBit(input int r, input int c);
      logic [CELLS-1:0] v;
      v = '0;
      v[r * W + c] = 1'b1;
      return v;
   endfunction

   // Reference generation computed directly on a 2-D view of the grid.
   function automatic logic [CELLS-1:0] lifeNext(input logic [CELLS-1:0] g);
      logic [CELLS-1:0] res;
      res = '0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            int n;
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  int rr;
                  int cc;
                  rr = r + dr;
                  cc = c + dc;
`ifdef LIFE_WRAP_EN
                  rr = (rr + H) % H;
                  cc = (cc + W) % W;
`endif
                  if (!(dr == 0 && dc == 0) && rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                     n = n + int'(g[rr * W + cc]);
                  end
               end
            end
            res[r * W + c] = (n == 3) || (g[r * W + c] && n == 2);
         end
      end
      return res;
   endfunction

   // Model: a step occupies CELLS+1 clocks after START is taken, then the grid advances one generation.
   always @(posedge CLK) begin
      if (RST) begin
         mGrid   = '0;
         mGen    = '0;
         mBusy   = 1'b0;
         mDone   = 1'b0;
         mCycles = 0;
      end else begin
         mDone = 1'b0;
         if (mBusy) begin
            mCycles = mCycles + 1;
            if (mCycles == CELLS + 1) begin
               mGrid = lifeNext(mGrid);
               mGen  = mGen + 16'd1;
               mDone = 1'b1;
               mBusy = 1'b0;
            end
         end else if (LOAD) begin
            mGrid = LOAD_DATA;
            mGen  = '0;
         end else if (START) begin
            mBusy   = 1'b1;
            mCycles = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [CELLS-1:0] actual,
                              input logic [CELLS-1:0] expected);
      tests = tests + 1;
      if (actual !== expected) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (checkEnable) begin
         checkOutput("model_grid", GRID, mGrid);
         checkOutput("model_generation", CELLS'(GENERATION), CELLS'(mGen));
         checkOutput("model_busy", CELLS'(BUSY), CELLS'(mBusy));
         checkOutput("model_done", CELLS'(DONE), CELLS'(mDone));
      end
   end

   task automatic applyStimulus(input logic load, input logic [CELLS-1:0] data, input logic start);
      @(negedge CLK);
      LOAD      = load;
      LOAD_DATA = data;
      START     = start;
   endtask

   // Waits for DONE (bounded); START is dropped after the first cycle unless holdStart is set.
   task automatic waitDone(input bit holdStart, output int busyCycles);
      bit seen;
      int i;
      seen       = 1'b0;
      busyCycles = 0;
      i          = 0;
      while (!seen && i < 200) begin
         @(negedge CLK);
         if (i == 0 && !holdStart) begin
            START = 1'b0;
         end
         if (BUSY === 1'b1) begin
            busyCycles = busyCycles + 1;
         end
         if (DONE === 1'b1) begin
            seen = 1'b1;
         end
         i = i + 1;
      end
      if (!seen) begin
         tests = tests + 1;
         fails = fails + 1;
         $display("[TB] FAIL done_timeout: got no DONE, expected DONE within 200 cycles");
      end
   endtask

   initial begin
      logic [CELLS-1:0] blinkH;
      logic [CELLS-1:0] blinkV;
      logic [CELLS-1:0] block;
      logic [CELLS-1:0] edgeRow;
      logic [CELLS-1:0] edgeStep1;
      logic [CELLS-1:0] edgeStep2;
      int               cyc;
      int               donePulses;

      block   = cellBit(6, 6) | cellBit(6, 7) | cellBit(7, 6) | cellBit(7, 7);
      blinkH  = cellBit(3, 2) | cellBit(3, 3) | cellBit(3, 4) | block;
      blinkV  = cellBit(2, 3) | cellBit(3, 3) | cellBit(4, 3) | block;
      edgeRow = cellBit(0, 3) | cellBit(0, 4) | cellBit(0, 5);
`ifdef LIFE_WRAP_EN
      edgeStep1 = cellBit(7, 4) | cellBit(0, 4) | cellBit(1, 4);
      edgeStep2 = edgeRow;
`else
      edgeStep1 = cellBit(0, 4) | cellBit(1, 4);
      edgeStep2 = '0;
`endif

      RST       = 1'b1;
      LOAD      = 1'b1;
      LOAD_DATA = '1;
      START     = 1'b1;
      repeat (2) @(negedge CLK);
      checkEnable = 1'b1;
      checkOutput("reset_grid", GRID, '0);
      checkOutput("reset_generation", CELLS'(GENERATION), '0);
      checkOutput("reset_busy", CELLS'(BUSY), '0);
      checkOutput("reset_done", CELLS'(DONE), '0);
      RST   = 1'b0;
      LOAD  = 1'b0;
      START = 1'b0;

      applyStimulus(1'b1, blinkH, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("load_grid", GRID, blinkH);

      applyStimulus(1'b0, '0, 1'b1);
      waitDone(1'b0, cyc);
      checkOutput("blinker_busy_cycles", CELLS'(cyc), CELLS'(65));
      checkOutput("blinker_done", CELLS'(DONE), CELLS'(1));
      checkOutput("blinker_grid1", GRID, blinkV);
      checkOutput("blinker_gen1", CELLS'(GENERATION), CELLS'(1));

      applyStimulus(1'b0, '0, 1'b1);
      waitDone(1'b0, cyc);
      checkOutput("blinker_grid2", GRID, blinkH);
      checkOutput("blinker_gen2", CELLS'(GENERATION), CELLS'(2));

      applyStimulus(1'b1, edgeRow, 1'b0);
      applyStimulus(1'b0, '0, 1'b1);
      waitDone(1'b0, cyc);
      checkOutput("edge_grid", GRID, edgeStep1);
      checkOutput("edge_gen", CELLS'(GENERATION), CELLS'(1));

      applyStimulus(1'b0, '0, 1'b1);
      waitDone(1'b1, cyc);
      checkOutput("held_start_grid", GRID, edgeStep2);
      @(negedge CLK);
      checkOutput("held_start_rearm_busy", CELLS'(BUSY), CELLS'(1));
      START = 1'b0;
      waitDone(1'b0, cyc);
      checkOutput("held_start_gen", CELLS'(GENERATION), CELLS'(3));
      checkOutput("held_start_grid2", GRID, edgeStep1 & lifeNext(edgeStep2) | lifeNext(edgeStep2));

      applyStimulus(1'b1, blinkH, 1'b0);
      applyStimulus(1'b0, '0, 1'b1);
      repeat (9) @(negedge CLK);
      START = 1'b0;
      applyStimulus(1'b1, '1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      waitDone(1'b0, cyc);
      checkOutput("scan_load_grid", GRID, blinkV);
      checkOutput("scan_load_gen", CELLS'(GENERATION), CELLS'(1));

      applyStimulus(1'b1, edgeRow, 1'b1);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("load_start_grid", GRID, edgeRow);
      checkOutput("load_start_busy", CELLS'(BUSY), '0);
      checkOutput("load_start_gen", CELLS'(GENERATION), '0);

      applyStimulus(1'b0, '0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0);
      repeat (19) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      checkOutput("midreset_grid", GRID, '0);
      checkOutput("midreset_busy", CELLS'(BUSY), '0);
      checkOutput("midreset_gen", CELLS'(GENERATION), '0);
      donePulses = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge CLK);
         if (DONE !== 1'b0) begin
            donePulses = donePulses + 1;
         end
      end
      checkOutput("midreset_no_done", CELLS'(donePulses), '0);

      applyStimulus(1'b1, blinkH, 1'b0);
      applyStimulus(1'b0, '0, 1'b1);
      waitDone(1'b0, cyc);
      checkOutput("post_reset_busy_cycles", CELLS'(cyc), CELLS'(65));
      checkOutput("post_reset_grid", GRID, blinkV);
      checkOutput("post_reset_gen", CELLS'(GENERATION), CELLS'(1));

      repeat (2) @(negedge CLK);
      checkEnable = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
